led_seq_ctrl: RTL

Controller that sequences the LED shift-register block: generates its one-cycle advance strobe (`o_valid`) at a switch-selected rate and drives its direction level (`o_reverse`), toggled by a push-button. Sits between the board switches/buttons and the LED pattern register in the top level. Contains the run/pause state machine, the programmable rate counter and the button conditioning.

---
 rtl/led_ctrl_pkg.sv | 27 ++
 rtl/btn_edge_sync.sv | 83 ++++++++
 rtl/led_seq_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/led_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// led_ctrl_pkg
// Shared constants for the LED sequencer controller: FSM state encodings,
// speed-select codes and default rate/debounce settings. The same values are
// used by the top level and the bench.
// ----------------------------------------------------------------------------
package led_ctrl_pkg;

    // FSM state encodings (also driven onto the status LEDs)
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;

    // Speed-select codes, 0 = fastest
    localparam logic [1:0] SPD_0 = 2'b00;
    localparam logic [1:0] SPD_1 = 2'b01;
    localparam logic [1:0] SPD_2 = 2'b10;
    localparam logic [1:0] SPD_3 = 2'b11;

    // Default terminal counts and button filter length
    localparam int unsigned LIM0_DEF     = (2**24) - 1;
    localparam int unsigned LIM1_DEF     = (2**25) - 1;
    localparam int unsigned LIM2_DEF     = (2**26) - 1;
    localparam int unsigned LIM3_DEF     = (2**27) - 1;
    localparam int unsigned DEBOUNCE_DEF = 2**20;

endpackage : led_ctrl_pkg

// File: rtl/btn_edge_sync.sv
// ----------------------------------------------------------------------------
// btn_edge_sync
// Conditions an asynchronous push-button: 2-FF synchronizer, optional
// debounce filter, then a rising-edge detector producing a one-cycle pulse.
// Optional feature macro: LED_SEQ_DEBOUNCE_EN (enables the debounce filter
// and the DEBOUNCE_CYCLES parameter).
// Ports:
//   clock     in   clock
//   i_reset   in   synchronous active-high reset
//   i_btn     in   raw button, asynchronous
//   o_rise_c  out  one-cycle pulse on a filtered rising edge (decoded from
//                  registers, no path from i_btn)
// ----------------------------------------------------------------------------
module btn_edge_sync
    import led_ctrl_pkg::*;
`ifdef LED_SEQ_DEBOUNCE_EN
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF
)
`endif
(
    input  logic clock,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_rise_c
);

    logic r_sync1;
    logic r_sync2;
    logic r_level_d;
    logic w_level;

    // Metastability synchronizer
    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

`ifdef LED_SEQ_DEBOUNCE_EN
    localparam int unsigned NB_DB = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [NB_DB-1:0] DB_LAST = NB_DB'(DEBOUNCE_CYCLES - 1);

    logic [NB_DB-1:0] r_db_cnt;
    logic             r_filt;

    // Filtered level follows the synchronized input only after
    // DEBOUNCE_CYCLES consecutive samples that differ from it.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_db_cnt <= '0;
            r_filt   <= 1'b0;
        end else if (r_sync2 == r_filt) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == DB_LAST) begin
            r_db_cnt <= '0;
            r_filt   <= r_sync2;
        end else begin
            r_db_cnt <= r_db_cnt + NB_DB'(1);
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_sync2;
`endif

    // Previous level for edge detection
    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_level_d <= 1'b0;
        end else begin
            r_level_d <= w_level;
        end
    end

    assign o_rise_c = w_level & ~r_level_d;

endmodule : btn_edge_sync

// File: rtl/led_seq_ctrl.sv
// ----------------------------------------------------------------------------
// led_seq_ctrl
// Sequencer for the LED shift register: run/pause FSM, programmable rate
// counter producing a one-cycle advance strobe, and a direction level toggled
// by a push-button.
// Optional feature macro: LED_SEQ_DEBOUNCE_EN (debounce the direction button).
// Ports:
//   clock      in   single clock
//   i_reset    in   synchronous active-high reset
//   i_enable   in   run switch (0 forces IDLE)
//   i_pause    in   pause switch
//   i_speed    in   rate select, 0 = fastest
//   i_btn_dir  in   raw direction button, asynchronous
//   o_valid    out  advance strobe, one cycle wide
//   o_reverse  out  direction level
//   o_state    out  FSM state for status LEDs
// ----------------------------------------------------------------------------
module led_seq_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned NB_COUNTER      = 32,
    parameter int unsigned LIM0            = LIM0_DEF,
    parameter int unsigned LIM1            = LIM1_DEF,
    parameter int unsigned LIM2            = LIM2_DEF,
    parameter int unsigned LIM3            = LIM3_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF
)(
    input  logic       clock,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic       i_pause,
    input  logic [1:0] i_speed,
    input  logic       i_btn_dir,
    output logic       o_valid,
    output logic       o_reverse,
    output logic [1:0] o_state
);

    // Elaboration-time sanity checks on the configuration
    if (((LIM0 | LIM1 | LIM2 | LIM3) >> NB_COUNTER) != 0) begin : g_bad_width
        $error("led_seq_ctrl: NB_COUNTER too narrow for LIMx");
    end
    if (DEBOUNCE_CYCLES == 0) begin : g_bad_debounce
        $error("led_seq_ctrl: DEBOUNCE_CYCLES must be at least 1");
    end

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [NB_COUNTER-1:0] r_count;
    logic [NB_COUNTER-1:0] w_count_nxt;
    logic [NB_COUNTER-1:0] r_limit;
    logic [NB_COUNTER-1:0] w_limit_nxt;
    logic [NB_COUNTER-1:0] w_lim_sel;
    logic                  w_wrap;
    logic                  r_reverse;
    logic                  w_dir_rise;

    // Direction button conditioning
`ifdef LED_SEQ_DEBOUNCE_EN
    btn_edge_sync #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_dir (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_btn    (i_btn_dir),
        .o_rise_c (w_dir_rise)
    );
`else
    btn_edge_sync u_btn_dir (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_btn    (i_btn_dir),
        .o_rise_c (w_dir_rise)
    );
`endif

    // Terminal-count select
    always_comb begin
        w_lim_sel = NB_COUNTER'(LIM0);
        case (i_speed)
            SPD_1:   w_lim_sel = NB_COUNTER'(LIM1);
            SPD_2:   w_lim_sel = NB_COUNTER'(LIM2);
            SPD_3:   w_lim_sel = NB_COUNTER'(LIM3);
            default: w_lim_sel = NB_COUNTER'(LIM0);
        endcase
    end

    assign w_wrap = (r_count == r_limit);

    // Next state and counter/limit update. The datapath action follows the
    // current state, so the edge leaving RUN still counts and the edge
    // leaving PAUSE still holds: pausing never adds or drops RUN cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_limit_nxt = r_limit;

        case (r_state)
            ST_IDLE: begin
                w_state_nxt = i_pause ? ST_PAUSE : ST_RUN;
                w_count_nxt = '0;
                w_limit_nxt = w_lim_sel;
            end
            ST_RUN: begin
                if (i_pause) begin
                    w_state_nxt = ST_PAUSE;
                end
                if (w_wrap) begin
                    w_count_nxt = '0;
                    w_limit_nxt = w_lim_sel;
                end else begin
                    w_count_nxt = r_count + NB_COUNTER'(1);
                end
            end
            ST_PAUSE: begin
                if (!i_pause) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = '0;
            end
        endcase

        // Run switch off overrides everything
        if (!i_enable) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = '0;
        end
    end

    // State, counter, limit and direction registers
    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_limit   <= NB_COUNTER'(LIM0);
            r_reverse <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_limit   <= w_limit_nxt;
            r_reverse <= r_reverse ^ w_dir_rise;
        end
    end

    assign o_valid   = (r_state == ST_RUN) && w_wrap;
    assign o_reverse = r_reverse;
    assign o_state   = r_state;

endmodule : led_seq_ctrl
